// File: rtl/vegeta_tile_scheduler_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | vegeta_tile_scheduler_if                                                   |
// | Handshake bundle between the tile scheduler and its host/data-control peers|
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
interface vegeta_tile_scheduler_if #(
  parameter int TILE_W = 8
);
  logic              start;
  logic [TILE_W-1:0] num_tiles;
  logic              busy;
  logic              done;
  logic              error;
  logic [TILE_W-1:0] tile_index;
  logic              wt_begin_load;
  logic              wt_L1_loaded;
  logic              wt_load_array;
  logic              wt_array_loaded;
  logic              in_start;
  logic              in_done;
  logic              out_start;
  logic              out_done;

  modport master (
    input  start, num_tiles, wt_L1_loaded, wt_array_loaded, in_done, out_done,
    output busy, done, error, tile_index, wt_begin_load, wt_load_array,
           in_start, out_start
  );

  modport slave (
    output start, num_tiles, wt_L1_loaded, wt_array_loaded, in_done, out_done,
    input  busy, done, error, tile_index, wt_begin_load, wt_load_array,
           in_start, out_start
  );
endinterface
`default_nettype wire

// File: rtl/vegeta_tile_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | vegeta_tile_scheduler                                                      |
// | Sequences weight fill/transfer, activation stream and drain per tile,      |
// | prefetching the next tile's weights into L1 during compute.                |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module vegeta_tile_scheduler #(
  parameter int TILE_W  = 8,
  parameter int TIMEOUT = 65535
) (
  input wire clk,
  input wire rst,
  vegeta_tile_scheduler_if.master bus
);

  localparam logic [16:0]       c_WDOG_LIMIT = 17'(TIMEOUT - 1);
  localparam logic [16:0]       c_WDOG_ONE   = 17'd1;
  localparam logic [TILE_W-1:0] c_ONE        = TILE_W'(1);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_FILL       = 3'd1,
    S_XFER       = 3'd2,
    S_WAIT_OUT   = 3'd3,
    S_COMPUTE    = 3'd4,
    S_LAST_DRAIN = 3'd5,
    S_FINISH     = 3'd6,
    S_ERROR      = 3'd7
  } state_t;

  state_t            r_state;
  logic [TILE_W-1:0] r_num_tiles;
  logic [TILE_W-1:0] r_tile_index;
  logic              r_l1_full;
  logic              r_pf_pending;
  logic              r_out_busy;
  logic [16:0]       r_wdog;
  logic              r_busy;
  logic              r_done;
  logic              r_error;
  logic              r_wt_begin_load;
  logic              r_wt_load_array;
  logic              r_in_start;
  logic              r_out_start;

  logic w_wait_state;
  logic w_l1_hit;
  logic w_out_free;
  logic w_last;
  logic w_timeout;

  assign w_wait_state = (r_state == S_FILL) || (r_state == S_XFER) ||
                        (r_state == S_WAIT_OUT) || (r_state == S_COMPUTE) ||
                        (r_state == S_LAST_DRAIN);
  // Same-cycle input pulses count as already captured so responses stay 1 cycle late.
  assign w_l1_hit   = r_l1_full | bus.wt_L1_loaded;
  assign w_out_free = ~r_out_busy | bus.out_done;
  assign w_last     = (r_tile_index == (r_num_tiles - c_ONE));
  assign w_timeout  = w_wait_state && (r_wdog == c_WDOG_LIMIT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state         <= S_IDLE;
      r_num_tiles     <= '0;
      r_tile_index    <= '0;
      r_l1_full       <= 1'b0;
      r_pf_pending    <= 1'b0;
      r_out_busy      <= 1'b0;
      r_wdog          <= '0;
      r_busy          <= 1'b0;
      r_done          <= 1'b0;
      r_error         <= 1'b0;
      r_wt_begin_load <= 1'b0;
      r_wt_load_array <= 1'b0;
      r_in_start      <= 1'b0;
      r_out_start     <= 1'b0;
    end else begin
      r_wt_begin_load <= 1'b0;
      r_wt_load_array <= 1'b0;
      r_in_start      <= 1'b0;
      r_out_start     <= 1'b0;
      r_done          <= 1'b0;
      r_wdog          <= w_wait_state ? (r_wdog + c_WDOG_ONE) : '0;

      if (bus.wt_L1_loaded && ((r_state == S_FILL) || r_pf_pending)) begin
        r_l1_full    <= 1'b1;
        r_pf_pending <= 1'b0;
      end
      if (bus.out_done) begin
        r_out_busy <= 1'b0;
      end

      if (w_timeout) begin
        r_state      <= S_ERROR;
        r_wdog       <= '0;
        r_pf_pending <= 1'b0;
        r_l1_full    <= 1'b0;
        r_out_busy   <= 1'b0;
        r_busy       <= 1'b0;
        r_error      <= 1'b1;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (bus.start) begin
              r_num_tiles  <= bus.num_tiles;
              r_error      <= 1'b0;
              r_tile_index <= '0;
              r_busy       <= 1'b1;
              if (bus.num_tiles == '0) begin
                r_state <= S_FINISH;
              end else begin
                r_wt_begin_load <= 1'b1;
                r_state         <= S_FILL;
              end
            end
          end
          S_FILL: begin
            if (w_l1_hit) begin
              r_wt_load_array <= 1'b1;
              r_l1_full       <= 1'b0;
              r_wdog          <= '0;
              r_state         <= S_XFER;
            end
          end
          S_XFER: begin
            // The array now holds this tile, so L1 is free for the next one.
            if (bus.wt_array_loaded) begin
              if (!w_last) begin
                r_wt_begin_load <= 1'b1;
                r_pf_pending    <= 1'b1;
              end
              r_wdog  <= '0;
              r_state <= S_WAIT_OUT;
            end
          end
          S_WAIT_OUT: begin
            if (w_out_free) begin
              r_in_start <= 1'b1;
              r_wdog     <= '0;
              r_state    <= S_COMPUTE;
            end
          end
          S_COMPUTE: begin
            if (bus.in_done) begin
              r_out_start <= 1'b1;
              r_out_busy  <= 1'b1;
              r_wdog      <= '0;
              if (w_last) begin
                r_state <= S_LAST_DRAIN;
              end else begin
                r_tile_index <= r_tile_index + c_ONE;
                r_state      <= S_FILL;
              end
            end
          end
          S_LAST_DRAIN: begin
            if (w_out_free) begin
              r_wdog  <= '0;
              r_state <= S_FINISH;
            end
          end
          S_FINISH: begin
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
          S_ERROR: begin
            r_busy  <= 1'b0;
            r_error <= 1'b1;
            r_state <= S_IDLE;
          end
          default: begin
            r_state <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign bus.busy          = r_busy;
  assign bus.done          = r_done;
  assign bus.error         = r_error;
  assign bus.tile_index    = r_tile_index;
  assign bus.wt_begin_load = r_wt_begin_load;
  assign bus.wt_load_array = r_wt_load_array;
  assign bus.in_start      = r_in_start;
  assign bus.out_start     = r_out_start;

endmodule
`default_nettype wire

// File: tb/tb_vegeta_tile_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_vegeta_tile_scheduler                                                   |
// | Scoreboard bench: expected pulse order queued at start, popped on output.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_vegeta_tile_scheduler;
  localparam int TILE_W = 8;
  localparam int K_BL = 0, K_LA = 1, K_IS = 2, K_OS = 3, K_DN = 4;

  logic clk = 1'b0;
  logic rst;
  initial forever #5 clk = ~clk;

  vegeta_tile_scheduler_if #(.TILE_W(TILE_W)) b1 ();
  vegeta_tile_scheduler_if #(.TILE_W(TILE_W)) b2 ();

  vegeta_tile_scheduler #(.TILE_W(TILE_W), .TIMEOUT(65535)) dut (
    .clk(clk), .rst(rst), .bus(b1));
  vegeta_tile_scheduler #(.TILE_W(TILE_W), .TIMEOUT(50)) dut_to (
    .clk(clk), .rst(rst), .bus(b2));

  typedef struct { int kind; int tidx; } ev_t;
  ev_t exp_q[$];
  int errors = 0, checks = 0, cyc = 0, busy_cycles = 0, start_cyc = 0;
  int fill_dly = 20, xfer_dly = 5, comp_dly = 30, drain_dly = 10;
  int bl_cyc[$], la_cyc[$], is_cyc[$], os_cyc[$], dn_cyc[$];
  int l1_cyc[$], al_cyc[$], id_cyc[$], od_cyc[$];

  initial forever begin @(posedge clk); cyc++; end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  function automatic logic [31:0] outs(input int which);
    if (which == 1)
      return 32'({b1.busy, b1.done, b1.error, b1.wt_begin_load, b1.wt_load_array,
                  b1.in_start, b1.out_start, b1.tile_index});
    return 32'({b2.busy, b2.done, b2.error, b2.wt_begin_load, b2.wt_load_array,
                b2.in_start, b2.out_start, b2.tile_index});
  endfunction

  function automatic int first(input int q[$], input int i);
    return (q.size() > i) ? q[i] : -1000;
  endfunction

  task automatic push(input int k, input int t);
    ev_t e;
    e.kind = k; e.tidx = t;
    exp_q.push_back(e);
  endtask

  // Pulse order for an n-tile run; tile_index advances with out_start of a non-last tile.
  task automatic expect_run(input int n);
    if (n == 0) begin push(K_DN, 0); return; end
    push(K_BL, 0); push(K_LA, 0);
    for (int t = 0; t < n; t++) begin
      if (t < n - 1) push(K_BL, t);
      push(K_IS, t);
      push(K_OS, (t < n - 1) ? t + 1 : t);
      if (t < n - 1) push(K_LA, t + 1);
    end
    push(K_DN, n - 1);
  endtask

  task automatic sb_pop(input int k);
    ev_t e;
    chk("sb_avail", 32'(exp_q.size() > 0), 1);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("sb_kind", k, e.kind);
      chk("sb_tidx", 32'(b1.tile_index), e.tidx);
    end
  endtask

  task automatic clear_rec();
    bl_cyc.delete(); la_cyc.delete(); is_cyc.delete(); os_cyc.delete(); dn_cyc.delete();
    l1_cyc.delete(); al_cyc.delete(); id_cyc.delete(); od_cyc.delete();
    busy_cycles = 0;
  endtask

  // Output monitor / scoreboard consumer
  initial forever begin
    @(negedge clk);
    if (!rst) begin
      if (b1.busy) busy_cycles++;
      if (b1.wt_begin_load) begin bl_cyc.push_back(cyc); sb_pop(K_BL); end
      if (b1.wt_load_array) begin la_cyc.push_back(cyc); sb_pop(K_LA); end
      if (b1.in_start)      begin is_cyc.push_back(cyc); sb_pop(K_IS); end
      if (b1.out_start)     begin os_cyc.push_back(cyc); sb_pop(K_OS); end
      if (b1.done)          begin dn_cyc.push_back(cyc); sb_pop(K_DN); end
    end
  end

  // Downstream responder for the main instance
  initial begin
    int fc, xc, cc, dc;
    fc = 0; xc = 0; cc = 0; dc = 0;
    forever begin
      @(negedge clk);
      b1.wt_L1_loaded = 1'b0; b1.wt_array_loaded = 1'b0;
      b1.in_done = 1'b0; b1.out_done = 1'b0;
      if (rst) begin
        fc = 0; xc = 0; cc = 0; dc = 0;
      end else begin
        if (fc > 0) begin fc--; if (fc == 0) begin b1.wt_L1_loaded = 1'b1; l1_cyc.push_back(cyc); end end
        if (xc > 0) begin xc--; if (xc == 0) begin b1.wt_array_loaded = 1'b1; al_cyc.push_back(cyc); end end
        if (cc > 0) begin cc--; if (cc == 0) begin b1.in_done = 1'b1; id_cyc.push_back(cyc); end end
        if (dc > 0) begin dc--; if (dc == 0) begin b1.out_done = 1'b1; od_cyc.push_back(cyc); end end
        if (b1.wt_begin_load) fc = fill_dly;
        if (b1.wt_load_array) xc = xfer_dly;
        if (b1.in_start)      cc = comp_dly;
        if (b1.out_start)     dc = drain_dly;
      end
    end
  end

  task automatic start1(input int n);
    b1.num_tiles = TILE_W'(n);
    b1.start = 1'b1;
    start_cyc = cyc;
    @(negedge clk);
    b1.start = 1'b0;
  endtask

  task automatic wait_drain(input string tag, input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin @(negedge clk); n++; end
    chk({tag, "_complete"}, exp_q.size(), 0);
    repeat (5) @(negedge clk);
  endtask

  function automatic logic b2_sig(input int k);
    case (k)
      K_BL:    return b2.wt_begin_load;
      K_LA:    return b2.wt_load_array;
      K_IS:    return b2.in_start;
      default: return b2.done;
    endcase
  endfunction

  task automatic wait_b2(input int k, input string tag);
    int n = 0;
    while (!b2_sig(k) && n < 40) begin @(negedge clk); n++; end
    chk(tag, 32'(b2_sig(k)), 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1);
  end

  initial begin
    int n, t0;
    rst = 1'b1;
    b1.start = 1'b0; b1.num_tiles = '0;
    b2.start = 1'b0; b2.num_tiles = '0;
    b2.wt_L1_loaded = 1'b0; b2.wt_array_loaded = 1'b0; b2.in_done = 1'b0; b2.out_done = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outs_main", outs(1), 0);
    chk("reset_outs_to", outs(2), 0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_reset_idle", outs(1), 0);

    // Single tile, 5-cycle responder
    fill_dly = 5; xfer_dly = 5; comp_dly = 5; drain_dly = 5;
    clear_rec(); expect_run(1); start1(1);
    wait_drain("single", 300);
    chk("single_bl_latency", first(bl_cyc, 0), start_cyc + 1);
    chk("single_bl_count", bl_cyc.size(), 1);
    chk("single_la_after_l1", first(la_cyc, 0), first(l1_cyc, 0) + 1);
    chk("single_os_after_id", first(os_cyc, 0), first(id_cyc, 0) + 1);
    chk("single_busy_span", busy_cycles, first(dn_cyc, 0) - first(bl_cyc, 0));

    // Three tiles with prefetch overlap
    fill_dly = 20; xfer_dly = 5; comp_dly = 30; drain_dly = 10;
    clear_rec(); expect_run(3); start1(3);
    wait_drain("three", 2000);
    chk("three_prefetch_bl", first(bl_cyc, 1), first(al_cyc, 0) + 1);
    chk("three_bl_count", bl_cyc.size(), 3);
    chk("three_la_count", la_cyc.size(), 3);
    chk("three_is_count", is_cyc.size(), 3);
    chk("three_os_count", os_cyc.size(), 3);
    chk("three_done_after_od", first(dn_cyc, 0), first(od_cyc, 2) + 2);

    // Zero tiles
    clear_rec(); expect_run(0); start1(0);
    wait_drain("zero", 50);
    chk("zero_done_latency", first(dn_cyc, 0), start_cyc + 2);
    chk("zero_no_handshake", bl_cyc.size() + la_cyc.size() + is_cyc.size() + os_cyc.size(), 0);

    // Output back-pressure on tile 0
    drain_dly = 100;
    clear_rec(); expect_run(2); start1(2);
    n = 0;
    while (os_cyc.size() < 1 && n < 500) begin @(negedge clk); n++; end
    chk("bp_os_seen", 32'(os_cyc.size() >= 1), 1);
    drain_dly = 10;
    wait_drain("bp", 2000);
    chk("bp_is_after_od", first(is_cyc, 1), first(od_cyc, 0) + 1);

    // wt_L1_loaded and in_done in the same cycle
    fill_dly = 11; comp_dly = 10; drain_dly = 10;
    clear_rec(); expect_run(2); start1(2);
    wait_drain("same", 2000);
    chk("same_cycle_align", first(l1_cyc, 1), first(id_cyc, 0));
    chk("same_la_after_os", first(la_cyc, 1), first(os_cyc, 0) + 1);

    // Reset during tile 1 compute, then restart with a start while busy
    fill_dly = 20; xfer_dly = 5; comp_dly = 30; drain_dly = 10;
    clear_rec(); expect_run(3); start1(3);
    n = 0;
    while (is_cyc.size() < 2 && n < 1000) begin @(negedge clk); n++; end
    chk("rst_reached_tile1", 32'(is_cyc.size() >= 2), 1);
    repeat (5) @(negedge clk);
    #2 rst = 1'b1;
    exp_q.delete();
    #1 chk("rst_async_outs", outs(1), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_release_idle", outs(1), 0);
    clear_rec(); expect_run(1); start1(1);
    repeat (3) @(negedge clk);
    chk("busy_before_restart", 32'(b1.busy), 1);
    start1(5);
    wait_drain("restart", 500);
    chk("restart_bl_count", bl_cyc.size(), 1);

    // Watchdog on the TIMEOUT=50 instance: in_done never arrives
    b2.num_tiles = TILE_W'(1); b2.start = 1'b1;
    @(negedge clk); b2.start = 1'b0;
    wait_b2(K_BL, "to_bl");
    b2.wt_L1_loaded = 1'b1;
    @(negedge clk); b2.wt_L1_loaded = 1'b0;
    wait_b2(K_LA, "to_la");
    b2.wt_array_loaded = 1'b1;
    @(negedge clk); b2.wt_array_loaded = 1'b0;
    wait_b2(K_IS, "to_is");
    t0 = cyc;
    repeat (49) @(negedge clk);
    chk("to_cycle49_error", 32'(b2.error), 0);
    chk("to_cycle49_busy", 32'(b2.busy), 1);
    @(negedge clk);
    chk("to_cycle50_at", cyc, t0 + 50);
    chk("to_cycle50_error", 32'(b2.error), 1);
    chk("to_cycle50_busy", 32'(b2.busy), 0);
    @(negedge clk);
    chk("to_error_sticky", 32'(b2.error), 1);
    repeat (3) @(negedge clk);
    b2.start = 1'b1;
    @(negedge clk); b2.start = 1'b0;
    chk("to_start_clears_error", 32'(b2.error), 0);
    chk("to_restart_busy", 32'(b2.busy), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
`default_nettype wire
